// File: rtl/uart_pkg.sv
// Shared UART package: TX/RX FSM state enum, oversample and data-length limits,
// and the helper that maps an arbitrary NBits request onto a legal frame length.
package uart_pkg;

   localparam int UART_OVERSAMPLE_DEF = 16;
   localparam int UART_NBITS_MIN      = 5;
   localparam int UART_NBITS_MAX      = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   // Out-of-range lengths fall back to a full byte.
   function automatic logic [3:0] uart_clamp_nbits(input logic [3:0] n);
      if (n >= 4'(UART_NBITS_MIN) && n <= 4'(UART_NBITS_MAX)) begin
         return n;
      end
      return 4'(UART_NBITS_MAX);
   endfunction

endpackage

// File: rtl/uart_tick_counter.sv
// Oversample counter: counts Tick pulses 0..OVERSAMPLE-1 while enabled and
// pulses period_end on the Tick that wraps it.
// Ports: clk, rst_n (sync, active-low), clr (highest priority), en, tick, period_end.
import uart_pkg::*;

module uart_tick_counter #(
   parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic tick,
   output logic period_end
);

   localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // clr wins over tick, so a Tick on the clearing edge is not counted.
   always_comb begin
      cnt_d      = cnt_q;
      period_end = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (en && tick) begin
         if (cnt_q == LAST) begin
            cnt_d      = '0;
            period_end = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, 5..8 data bits LSB first, optional parity
// (compile with UART_TX_PARITY_EN), STOP_BITS stop bits, timed by a 16x Tick.
// Ports: Clk, Rst_n (sync, active-low), Tick, TxEn, NBits, TxData, TxValid,
//        TxReady, Tx, TxBusy, TxDone, ParityOdd (parity build only).
import uart_pkg::*;

module uart_tx_framer #(
   parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
   parameter int STOP_BITS  = 1
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Tick,
   input  logic       TxEn,
   input  logic [3:0] NBits,
   input  logic [7:0] TxData,
   input  logic       TxValid,
   output logic       TxReady,
   output logic       Tx,
   output logic       TxBusy,
`ifdef UART_TX_PARITY_EN
   output logic       TxDone,
   input  logic       ParityOdd
`else
   output logic       TxDone
`endif
);

   uart_tx_state_t state_q, state_d;
   logic [7:0]     sh_q, sh_d;
   logic [3:0]     len_q, len_d;
   logic [3:0]     bit_q, bit_d;
   logic           tx_q, tx_d;
   logic           done_q, done_d;
   logic           accept;
   logic           period_end;
   logic [3:0]     len_c;

`ifdef UART_TX_PARITY_EN
   logic           par_q, par_d;
   logic [7:0]     par_mask;
`endif

   assign TxReady = (state_q == IDLE) && TxEn;
   assign TxBusy  = (state_q != IDLE);
   assign Tx      = tx_q;
   assign TxDone  = done_q;
   assign accept  = TxValid && TxReady;
   assign len_c   = uart_clamp_nbits(NBits);

`ifdef UART_TX_PARITY_EN
   // Only the bits that will actually be sent contribute to parity.
   assign par_mask = 8'hFF >> (4'd8 - len_c);
`endif

   uart_tick_counter #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_tick (
      .clk       (Clk),
      .rst_n     (Rst_n),
      .clr       (accept),
      .en        (TxBusy),
      .tick      (Tick),
      .period_end(period_end)
   );

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      len_d   = len_q;
      bit_d   = bit_q;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               sh_d    = TxData;
               len_d   = len_c;
               bit_d   = '0;
`ifdef UART_TX_PARITY_EN
               par_d   = (^(TxData & par_mask)) ^ ParityOdd;
`endif
               state_d = START;
            end
         end
         START: begin
            if (period_end) begin
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (period_end) begin
               sh_d = {1'b0, sh_q[7:1]};
               if (bit_q == len_q - 4'd1) begin
                  bit_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (period_end) begin
               bit_d   = '0;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (period_end) begin
               if (bit_q == 4'(STOP_BITS - 1)) begin
                  bit_d   = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Line level is registered from the state being entered.
      tx_d = 1'b1;
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = par_q;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         sh_q    <= '0;
         len_q   <= 4'(UART_NBITS_MAX);
         bit_q   <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         len_q   <= len_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed self-checking bench for uart_tx_framer: Tick every 4 Clk, so one
// bit period is 64 Clk; the line is sampled mid-bit and TxDone timing checked.
module tb_uart_tx_framer;

   localparam int OS   = 16;
   localparam int SB   = 1;
   localparam int TDIV = 4;
   localparam int BITC = OS * TDIV;

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b0;
   logic       Tick = 1'b0;
   logic       TxEn = 1'b0;
   logic [3:0] NBits = 4'd8;
   logic [7:0] TxData = 8'h00;
   logic       TxValid = 1'b0;
   logic       ParityOdd = 1'b0;
   logic       TxReady;
   logic       Tx;
   logic       TxBusy;
   logic       TxDone;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit tick_on = 1'b0;
   int tdiv = 0;

   uart_tx_framer #(
      .OVERSAMPLE(OS),
      .STOP_BITS (SB)
   ) dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .Tick     (Tick),
      .TxEn     (TxEn),
      .NBits    (NBits),
      .TxData   (TxData),
      .TxValid  (TxValid),
      .TxReady  (TxReady),
      .Tx       (Tx),
      .TxBusy   (TxBusy),
`ifdef UART_TX_PARITY_EN
      .TxDone   (TxDone),
      .ParityOdd(ParityOdd)
`else
      .TxDone   (TxDone)
`endif
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   always @(negedge Clk) begin
      if (tick_on) begin
         tdiv = (tdiv == TDIV - 1) ? 0 : tdiv + 1;
         Tick = (tdiv == 0);
      end else begin
         tdiv = 0;
         Tick = 1'b0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge Clk);
   endtask

   task automatic accept_frame(input string nm, input logic [7:0] d,
                               input logic [3:0] n, input bit hold,
                               output int a);
      bit ok;
      ok = 1'b0;
      a = cyc;
      TxData = d;
      NBits = n;
      TxValid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (TxReady) begin
            @(negedge Clk);
            a = cyc;
            ok = 1'b1;
            break;
         end
         @(negedge Clk);
      end
      if (!hold) TxValid = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s_accept got=timeout required=accept", nm);
      end
      checks++;
      if (Tx !== 1'b0 || TxBusy !== 1'b1) begin
         failures++;
         $display("FAIL %s_start_latency Tx=%b Busy=%b required Tx=0 Busy=1",
                  nm, Tx, TxBusy);
      end
   endtask

   task automatic check_frame(input string nm, input int a,
                              input logic [7:0] d, input int n,
                              input bit pen, input logic pbit,
                              output int dcyc);
      int total;
      logic ex;
      logic [7:0] dv;
      dv = d;
      total = 1 + n + (pen ? 1 : 0) + SB;
      for (int k = 0; k < total; k++) begin
         wait_cyc(a + BITC / 2 + BITC * k);
         if (k == 0) ex = 1'b0;
         else if (k <= n) ex = dv[k-1];
         else if (pen && k == n + 1) ex = pbit;
         else ex = 1'b1;
         checks++;
         if (Tx !== ex) begin
            failures++;
            $display("FAIL %s_bit%0d Tx=%b required=%b", nm, k, Tx, ex);
         end
         checks++;
         if (TxReady !== 1'b0 || TxBusy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy%0d Ready=%b Busy=%b required Ready=0 Busy=1",
                     nm, k, TxReady, TxBusy);
         end
      end
      while (TxDone !== 1'b1 && cyc < a + total * BITC + 20) @(negedge Clk);
      dcyc = cyc;
      checks++;
      if (TxDone !== 1'b1 || dcyc < a + total * BITC - 3 ||
          dcyc > a + total * BITC) begin
         failures++;
         $display("FAIL %s_done_time got=%0d required=%0d..%0d done=%b",
                  nm, dcyc - a, total * BITC - 3, total * BITC, TxDone);
      end
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      TxEn = 1'b1;
      repeat (3) @(negedge Clk);
      checks++;
      if (Tx !== 1'b1 || TxBusy !== 1'b0 || TxDone !== 1'b0) begin
         failures++;
         $display("FAIL reset_state Tx=%b Busy=%b Done=%b required 1 0 0",
                  Tx, TxBusy, TxDone);
      end
      checks++;
      if (TxReady !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got=%b required=1", TxReady);
      end
      Rst_n = 1'b1;
      tick_on = 1'b1;
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_frame_8n1();
      int a;
      int dc;
      accept_frame("f8n1", 8'h55, 4'd8, 1'b0, a);
      // Mid-frame input changes must not disturb the frame.
      TxData = 8'h00;
      NBits = 4'd5;
      TxEn = 1'b0;
      check_frame("f8n1", a, 8'h55, 8, 1'b0, 1'b0, dc);
      @(negedge Clk);
      checks++;
      if (TxDone !== 1'b0) begin
         failures++;
         $display("FAIL f8n1_done_width got=%b required=0", TxDone);
      end
      checks++;
      if (TxReady !== 1'b0) begin
         failures++;
         $display("FAIL f8n1_en_gate got=%b required=0", TxReady);
      end
      TxEn = 1'b1;
      #1;
      checks++;
      if (TxReady !== 1'b1) begin
         failures++;
         $display("FAIL f8n1_en_ready got=%b required=1", TxReady);
      end
      @(negedge Clk);
   endtask

   task automatic test_short_frame();
      int a;
      int dc;
      accept_frame("short", 8'hFF, 4'd5, 1'b0, a);
      check_frame("short", a, 8'hFF, 5, 1'b0, 1'b0, dc);
      @(negedge Clk);
   endtask

   task automatic test_illegal_len();
      int a;
      int dc;
      accept_frame("illegal", 8'h81, 4'd12, 1'b0, a);
      check_frame("illegal", a, 8'h81, 8, 1'b0, 1'b0, dc);
      @(negedge Clk);
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      int a;
      int dc;
      ParityOdd = 1'b0;
      accept_frame("par_even", 8'h07, 4'd8, 1'b0, a);
      check_frame("par_even", a, 8'h07, 8, 1'b1, 1'b1, dc);
      @(negedge Clk);
      ParityOdd = 1'b1;
      accept_frame("par_odd", 8'h07, 4'd8, 1'b0, a);
      check_frame("par_odd", a, 8'h07, 8, 1'b1, 1'b0, dc);
      @(negedge Clk);
      ParityOdd = 1'b0;
      accept_frame("par_5b", 8'hEF, 4'd5, 1'b0, a);
      check_frame("par_5b", a, 8'hEF, 5, 1'b1, 1'b0, dc);
      @(negedge Clk);
   endtask
`endif

   task automatic test_back_to_back();
      int a;
      int dc;
      accept_frame("b2b_a", 8'hA5, 4'd8, 1'b1, a);
      TxData = 8'h3C;
      check_frame("b2b_a", a, 8'hA5, 8, 1'b0, 1'b0, dc);
      checks++;
      if (TxReady !== 1'b1 || Tx !== 1'b1) begin
         failures++;
         $display("FAIL b2b_gap Ready=%b Tx=%b required Ready=1 Tx=1",
                  TxReady, Tx);
      end
      @(negedge Clk);
      TxValid = 1'b0;
      checks++;
      if (Tx !== 1'b0 || TxBusy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_second_accept Tx=%b Busy=%b required Tx=0 Busy=1",
                  Tx, TxBusy);
      end
      check_frame("b2b_b", dc + 1, 8'h3C, 8, 1'b0, 1'b0, dc);
      @(negedge Clk);
   endtask

   task automatic test_reset_mid();
      int a;
      bit seen;
      accept_frame("rstmid", 8'h00, 4'd8, 1'b0, a);
      wait_cyc(a + BITC / 2 + BITC * 4);
      checks++;
      if (Tx !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_pre Tx=%b required=0", Tx);
      end
      Rst_n = 1'b0;
      @(negedge Clk);
      Rst_n = 1'b1;
      checks++;
      if (Tx !== 1'b1 || TxBusy !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_abort Tx=%b Busy=%b required Tx=1 Busy=0",
                  Tx, TxBusy);
      end
      seen = 1'b0;
      for (int i = 0; i < 800; i++) begin
         @(negedge Clk);
         if (TxDone === 1'b1 || Tx !== 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL rstmid_no_done got=activity required=idle");
      end
   endtask

   task automatic test_tick_stall();
      int a;
      int t0;
      tick_on = 1'b0;
      accept_frame("stall", 8'h55, 4'd8, 1'b0, a);
      repeat (300) @(negedge Clk);
      checks++;
      if (Tx !== 1'b0 || TxBusy !== 1'b1) begin
         failures++;
         $display("FAIL stall_hold Tx=%b Busy=%b required Tx=0 Busy=1",
                  Tx, TxBusy);
      end
      tick_on = 1'b1;
      t0 = cyc;
      while (TxDone !== 1'b1 && cyc < t0 + 10 * BITC + 20) @(negedge Clk);
      checks++;
      if (TxDone !== 1'b1 || cyc < t0 + 10 * BITC - 8) begin
         failures++;
         $display("FAIL stall_resume done=%b after=%0d required=%0d..%0d",
                  TxDone, cyc - t0, 10 * BITC - 8, 10 * BITC + 4);
      end
      @(negedge Clk);
   endtask

   initial begin
      @(negedge Clk);
      test_reset();
      test_frame_8n1();
      test_short_frame();
      test_illegal_len();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_back_to_back();
      test_reset_mid();
      test_tick_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
